// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// Optional statistics outputs are enabled by defining SDRAM_ARB_STATS_EN.
package sdram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} arb_state_t;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 32;

   // Width of a binary port index; never below one bit.
   function automatic int idx_w(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: starved ports first (lowest index), then port 0,
// then round-robin over ports 1..NUM_REQ-1 starting at rr_ptr.
module sdram_arb_pick
   import sdram_arb_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   localparam int IW      = idx_w(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] starved,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx,
   output logic               found
);

   always_comb begin
      int c;
      grant_idx = '0;
      found     = 1'b0;
      c         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && valid[i] && starved[i]) begin
            found     = 1'b1;
            grant_idx = IW'(i);
         end
      end
      if (!found && valid[0]) begin
         found     = 1'b1;
         grant_idx = '0;
      end
      // rr_ptr lies in 1..NUM_REQ-1, so one subtraction is enough to wrap.
      for (int k = 0; k < NUM_REQ - 1; k++) begin
         c = int'(rr_ptr) + k;
         if (c >= NUM_REQ)
            c = c - (NUM_REQ - 1);
         if (!found && valid[c]) begin
            found     = 1'b1;
            grant_idx = IW'(c);
         end
      end
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant[i] = found && (grant_idx == IW'(i));
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port among NUM_REQ requesters, one transaction in flight.
// Define SDRAM_ARB_STATS_EN to add per-port grant counters and peak-wait statistics.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 64
)(
   input  logic                        clk_sdram,
   input  logic                        reset_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ-1:0]          req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
   input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask_i,
   output logic [NUM_REQ-1:0]          req_rvalid_o,
   output logic [DATA_W-1:0]           rdata_o,
   output logic                        mem_valid_o,
   input  logic                        mem_ready_i,
   output logic                        mem_we_o,
   output logic [ADDR_W-1:0]           mem_addr_o,
   output logic [DATA_W-1:0]           mem_wdata_o,
   output logic [DATA_W/8-1:0]         mem_wmask_o,
   input  logic                        mem_rvalid_i,
   input  logic [DATA_W-1:0]           mem_rdata_i
`ifdef SDRAM_ARB_STATS_EN
  ,output logic [NUM_REQ*16-1:0]       stat_grants_o,
   output logic [(NUM_REQ-1)*8-1:0]    stat_max_wait_o,
   input  logic                        stat_clear_i
`endif
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int MW = DATA_W / 8;
   localparam int CW = $clog2(MAX_WAIT + 1);

   arb_state_t          state;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       owner;
   logic [NUM_REQ-1:0]  starved;
   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  grant_fire;
   logic [IW-1:0]       grant_idx;
   logic                found;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [MW-1:0]       sel_wmask;

   sdram_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid     (req_valid_i),
      .starved   (starved),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .found     (found)
   );

   assign grant_fire  = (state == IDLE) ? grant : '0;
   // Held low during reset so a requester cannot mistake a reset cycle for acceptance.
   assign req_ready_o = reset_i ? '0 : grant_fire;
   assign starved[0]  = 1'b0;

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wmask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we_i[i];
            sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            sel_wmask = req_wmask_i[i*MW +: MW];
         end
      end
   end

   genvar gi;
   for (gi = 1; gi < NUM_REQ; gi++) begin : g_wait
      logic [CW-1:0] cnt;
      always_ff @(posedge clk_sdram or posedge reset_i) begin
         if (reset_i)
            cnt <= '0;
         else if (!req_valid_i[gi] || grant_fire[gi])
            cnt <= '0;
         else if (cnt != CW'(MAX_WAIT))
            cnt <= cnt + CW'(1);
      end
      assign starved[gi] = (cnt == CW'(MAX_WAIT));
`ifdef SDRAM_ARB_STATS_EN
      logic [7:0] sat;
      logic [7:0] peak;
      always_comb sat = (32'(cnt) > 32'd255) ? 8'hFF : 8'(cnt);
      always_ff @(posedge clk_sdram or posedge reset_i) begin
         if (reset_i)
            peak <= '0;
         else if (stat_clear_i)
            peak <= '0;
         else if (sat > peak)
            peak <= sat;
      end
      assign stat_max_wait_o[(gi-1)*8 +: 8] = peak;
`endif
   end

`ifdef SDRAM_ARB_STATS_EN
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_grants
      logic [15:0] cnt;
      always_ff @(posedge clk_sdram or posedge reset_i) begin
         if (reset_i)
            cnt <= '0;
         else if (stat_clear_i)
            cnt <= '0;
         else if (grant_fire[gi])
            cnt <= cnt + 16'd1;
      end
      assign stat_grants_o[gi*16 +: 16] = cnt;
   end
`endif

   always_ff @(posedge clk_sdram or posedge reset_i) begin
      if (reset_i) begin
         state        <= IDLE;
         rr_ptr       <= IW'(1);
         owner        <= '0;
         mem_valid_o  <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_wmask_o  <= '0;
         rdata_o      <= '0;
         req_rvalid_o <= '0;
      end else begin
         req_rvalid_o <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  owner       <= grant_idx;
                  mem_valid_o <= 1'b1;
                  mem_we_o    <= sel_we;
                  mem_addr_o  <= sel_addr;
                  mem_wdata_o <= sel_wdata;
                  mem_wmask_o <= sel_wmask;
                  if (grant_idx != '0)
                     rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? IW'(1) : grant_idx + IW'(1);
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ready_i) begin
                  mem_valid_o <= 1'b0;
                  state       <= mem_we_o ? IDLE : WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (mem_rvalid_i) begin
                  rdata_o      <= mem_rdata_i;
                  req_rvalid_o <= NUM_REQ'(1) << owner;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
